// File: rtl/sram_controller_if.sv
// ----------------------------------------------------------------------------
// sram_controller_if
//   Bundles the MEM-stage side of the SRAM controller into one interface.
//   master : MEM stage (drives requests, receives load data and ready)
//   slave  : sram_controller
//   Signals:
//     wr_en       store request, level, held until ready
//     rd_en       load request, level, held until ready
//     address     byte address, word aligned (bits [1:0] ignored)
//     write_data  store data
//     read_data   registered load data
//     ready       1 = no access pending / access completes this cycle
// ----------------------------------------------------------------------------
interface sram_controller_if;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    modport master (
        output wr_en, rd_en, address, write_data,
        input  read_data, ready
    );

    modport slave (
        input  wr_en, rd_en, address, write_data,
        output read_data, ready
    );
endinterface

// File: rtl/sram_controller.sv
// ----------------------------------------------------------------------------
// sram_controller
//   Bridges the 32-bit MEM-stage data interface to a 16-bit external SRAM
//   with an 18-bit halfword address and a shared data bus. Every 32-bit
//   access is split into a low-halfword phase and a high-halfword phase,
//   each WAIT_CYCLES long; ready stays low while the access is in flight.
//   Ports:
//     clk        system clock, all state on rising edge
//     rst        synchronous, active-high reset
//     bus        MEM-stage request/response interface (slave side)
//     sram_addr  SRAM halfword address
//     sram_dq    SRAM data bus (driven here only while sram_we_n = 0)
//     sram_we_n  0 = write at clock edge, 1 = SRAM drives sram_dq
// ----------------------------------------------------------------------------
module sram_controller #(
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    sram_controller_if.slave bus,
    output logic [17:0]      sram_addr,
    inout  wire  [15:0]      sram_dq,
    output logic             sram_we_n
);
    typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_DONE} state_t;

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_next;
    logic        r_op_wr;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;

    logic        w_req;
    logic        w_last;
    logic [31:0] w_off;
    logic [15:0] w_dq_out;
    logic        w_unused;

    assign w_req  = bus.wr_en | bus.rd_en;
    assign w_last = (r_cnt == LAST_CNT);

    // Offset wraps modulo 2^32; bits above 18 are dropped, so addresses
    // outside the SRAM window alias onto it silently.
    assign w_off    = r_addr - BASE_ADDR;
    assign w_unused = ^{w_off[31:19], w_off[1:0]};

    // Control state, operation type and load data
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_op_wr <= 1'b0;
            r_rdata <= 32'd0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (r_state == S_IDLE && w_req) begin
                r_op_wr <= bus.wr_en;  // store wins when both are requested
            end
            // Load data is captured on the last cycle of each phase so the
            // SRAM has the full phase to settle.
            if (r_state == S_LOW && w_last && !r_op_wr) begin
                r_rdata[15:0] <= sram_dq;
            end
            if (r_state == S_HIGH && w_last && !r_op_wr) begin
                r_rdata[31:16] <= sram_dq;
            end
        end
    end

    // Request operands, latched once so a dropped request cannot disturb
    // an access already in flight
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && w_req) begin
            r_addr  <= bus.address;
            r_wdata <= bus.write_data;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_next     = S_LOW;
                    w_cnt_next = 4'd0;
                end
            end
            S_LOW: begin
                if (w_last) begin
                    w_next     = S_HIGH;
                    w_cnt_next = 4'd0;
                end else begin
                    w_cnt_next = r_cnt + 4'd1;
                end
            end
            S_HIGH: begin
                if (w_last) begin
                    w_next     = S_DONE;
                    w_cnt_next = 4'd0;
                end else begin
                    w_cnt_next = r_cnt + 4'd1;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        sram_addr = 18'd0;
        sram_we_n = 1'b1;
        w_dq_out  = r_wdata[15:0];
        bus.ready = 1'b0;
        case (r_state)
            S_IDLE: bus.ready = ~w_req;
            S_LOW: begin
                sram_addr = {w_off[18:2], 1'b0};
                sram_we_n = ~r_op_wr;
            end
            S_HIGH: begin
                sram_addr = {w_off[18:2], 1'b1};
                sram_we_n = ~r_op_wr;
                w_dq_out  = r_wdata[31:16];
            end
            S_DONE:  bus.ready = 1'b1;
            default: bus.ready = 1'b0;
        endcase
    end

    assign bus.read_data = r_rdata;

    // The bus is driven strictly under sram_we_n = 0 so the SRAM and the
    // controller can never drive it at the same time.
    assign sram_dq = sram_we_n ? 16'hzzzz : w_dq_out;

endmodule
